// File: rtl/timer_nch.sv
// timer_nch: NCH-channel memory-mapped timer with per-channel prescaler and one-shot/periodic/PWM modes.
// Define TIMER_CASCADE_EN to let channel i>0 tick from channel i-1's expiry (CTRL.cascade).
module timer_nch #(
  parameter int NCH = 4,
  parameter int CW  = 32,
  parameter int PSW = 8,
  parameter int AW  = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           sel,
  input  logic           we,
  input  logic [AW-1:0]  addr,
  input  logic [31:0]    wdata,
  output logic [31:0]    rdata,
  output logic [NCH-1:0] ch_out,
  output logic           irq
);

  localparam int CIW = AW - 2;

  localparam logic [1:0] REG_LOAD   = 2'd0;
  localparam logic [1:0] REG_CTRL   = 2'd1;
  localparam logic [1:0] REG_CMP    = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam logic [CW-1:0]  CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]  CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [PSW-1:0] PSC_ZERO = {PSW{1'b0}};
  localparam logic [PSW-1:0] PSC_ONE  = {{(PSW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    MODE_ONESHOT  = 2'd0,
    MODE_PERIODIC = 2'd1,
    MODE_PWM      = 2'd2,
    MODE_RSVD     = 2'd3
  } mode_e;

  logic [CW-1:0]  load_r       [NCH];
  logic [CW-1:0]  cmp_r        [NCH];
  logic [CW-1:0]  count_r      [NCH];
  logic [PSW-1:0] psc_r        [NCH];
  logic [PSW-1:0] pscnt_r      [NCH];
  mode_e          mode_r       [NCH];
  logic [NCH-1:0] en_r;
  logic [NCH-1:0] irq_en_r;
  logic [NCH-1:0] cascade_r;
  logic [NCH-1:0] done_r;
  logic [NCH-1:0] out_r;

  logic [CW-1:0]  load_nxt_s   [NCH];
  logic [CW-1:0]  cmp_nxt_s    [NCH];
  logic [CW-1:0]  count_nxt_s  [NCH];
  logic [PSW-1:0] psc_nxt_s    [NCH];
  logic [PSW-1:0] pscnt_nxt_s  [NCH];
  mode_e          mode_nxt_s   [NCH];
  logic [NCH-1:0] en_nxt_s;
  logic [NCH-1:0] irq_en_nxt_s;
  logic [NCH-1:0] cascade_nxt_s;
  logic [NCH-1:0] done_nxt_s;
  logic [NCH-1:0] out_nxt_s;

  logic [CIW-1:0] ch_idx_s;
  logic [1:0]     reg_s;
  logic [31:0]    rd_ch_s      [NCH];
  logic [31:0]    rd_val_s;

  assign ch_idx_s = addr[AW-1:2];
  assign reg_s    = addr[1:0];
  assign ch_out   = out_r;
  assign irq      = |(done_r & irq_en_r);

  // Per-channel next state: bus writes, prescaler, tick/expiry, sticky done and channel output.
  always_comb begin
    logic hit_v, wr_load_v, wr_ctrl_v, wr_cmp_v, wr_stat_v;
    logic start_v, run_v, use_cas_v, psc_tick_v, tick_v, expire_v, cas_prev_v;
    cas_prev_v = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      hit_v     = sel && we && (ch_idx_s == CIW'(i));
      wr_load_v = hit_v && (reg_s == REG_LOAD);
      wr_ctrl_v = hit_v && (reg_s == REG_CTRL);
      wr_cmp_v  = hit_v && (reg_s == REG_CMP);
      wr_stat_v = hit_v && (reg_s == REG_STATUS);
      start_v   = wr_ctrl_v && wdata[0] && !en_r[i];
      run_v     = en_r[i] && (mode_r[i] != MODE_RSVD);
`ifdef TIMER_CASCADE_EN
      use_cas_v = (i > 0) && cascade_r[i];
`else
      use_cas_v = 1'b0;
`endif
      if (use_cas_v) begin
        psc_tick_v = cas_prev_v;
      end else begin
        psc_tick_v = (pscnt_r[i] >= psc_r[i]);
      end
      // A CTRL write in the same cycle swallows the tick.
      tick_v     = run_v && psc_tick_v && !wr_ctrl_v;
      expire_v   = tick_v && (count_r[i] == CNT_ZERO);
      cas_prev_v = expire_v;

      if (wr_load_v) begin
        load_nxt_s[i] = wdata[CW-1:0];
      end else begin
        load_nxt_s[i] = load_r[i];
      end
      if (wr_cmp_v) begin
        cmp_nxt_s[i] = wdata[CW-1:0];
      end else begin
        cmp_nxt_s[i] = cmp_r[i];
      end

      if (wr_ctrl_v) begin
        en_nxt_s[i]     = wdata[0];
        mode_nxt_s[i]   = mode_e'(wdata[2:1]);
        irq_en_nxt_s[i] = wdata[3];
        psc_nxt_s[i]    = wdata[8 +: PSW];
`ifdef TIMER_CASCADE_EN
        cascade_nxt_s[i] = wdata[4];
`else
        cascade_nxt_s[i] = 1'b0;
`endif
      end else begin
        en_nxt_s[i]      = en_r[i] && !(expire_v && (mode_r[i] == MODE_ONESHOT));
        mode_nxt_s[i]    = mode_r[i];
        irq_en_nxt_s[i]  = irq_en_r[i];
        psc_nxt_s[i]     = psc_r[i];
        cascade_nxt_s[i] = cascade_r[i];
      end

      if (start_v || use_cas_v) begin
        pscnt_nxt_s[i] = PSC_ZERO;
      end else if (run_v && !wr_ctrl_v) begin
        if (psc_tick_v) begin
          pscnt_nxt_s[i] = PSC_ZERO;
        end else begin
          pscnt_nxt_s[i] = pscnt_r[i] + PSC_ONE;
        end
      end else begin
        pscnt_nxt_s[i] = pscnt_r[i];
      end

      if (start_v) begin
        count_nxt_s[i] = load_r[i];
      end else if (expire_v) begin
        if (mode_r[i] == MODE_ONESHOT) begin
          count_nxt_s[i] = count_r[i];
        end else begin
          count_nxt_s[i] = load_r[i];
        end
      end else if (tick_v) begin
        count_nxt_s[i] = count_r[i] - CNT_ONE;
      end else begin
        count_nxt_s[i] = count_r[i];
      end

      done_nxt_s[i] = expire_v || (done_r[i] && !(wr_stat_v && wdata[0]));

      if (expire_v && (mode_r[i] != MODE_PWM)) begin
        out_nxt_s[i] = 1'b1;
      end else if (en_nxt_s[i] && (mode_nxt_s[i] == MODE_PWM)) begin
        out_nxt_s[i] = (count_nxt_s[i] < cmp_nxt_s[i]);
      end else begin
        out_nxt_s[i] = 1'b0;
      end
    end
  end

  // Per-channel readback words, OR-selected by channel index; out-of-range indices read 0.
  always_comb begin
    rd_val_s = 32'd0;
    for (int i = 0; i < NCH; i++) begin
      rd_ch_s[i] = 32'd0;
      case (reg_s)
        REG_LOAD: rd_ch_s[i] = 32'(load_r[i]);
        REG_CTRL: begin
          rd_ch_s[i][0]          = en_r[i];
          rd_ch_s[i][2:1]        = mode_r[i];
          rd_ch_s[i][3]          = irq_en_r[i];
          rd_ch_s[i][4]          = cascade_r[i];
          rd_ch_s[i][8 +: PSW]   = psc_r[i];
        end
        REG_CMP:    rd_ch_s[i] = 32'(count_r[i]);
        REG_STATUS: rd_ch_s[i][0] = done_r[i];
        default:    rd_ch_s[i] = 32'd0;
      endcase
      rd_val_s = rd_val_s | (rd_ch_s[i] & {32{ch_idx_s == CIW'(i)}});
    end
  end

  // Channel state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        load_r[i]  <= CNT_ZERO;
        cmp_r[i]   <= CNT_ZERO;
        count_r[i] <= CNT_ZERO;
        psc_r[i]   <= PSC_ZERO;
        pscnt_r[i] <= PSC_ZERO;
        mode_r[i]  <= MODE_ONESHOT;
      end
      en_r      <= {NCH{1'b0}};
      irq_en_r  <= {NCH{1'b0}};
      cascade_r <= {NCH{1'b0}};
      done_r    <= {NCH{1'b0}};
      out_r     <= {NCH{1'b0}};
    end else begin
      for (int i = 0; i < NCH; i++) begin
        load_r[i]  <= load_nxt_s[i];
        cmp_r[i]   <= cmp_nxt_s[i];
        count_r[i] <= count_nxt_s[i];
        psc_r[i]   <= psc_nxt_s[i];
        pscnt_r[i] <= pscnt_nxt_s[i];
        mode_r[i]  <= mode_nxt_s[i];
      end
      en_r      <= en_nxt_s;
      irq_en_r  <= irq_en_nxt_s;
      cascade_r <= cascade_nxt_s;
      done_r    <= done_nxt_s;
      out_r     <= out_nxt_s;
    end
  end

  // Read data: captured on a read strobe, held until the next one.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= 32'd0;
    end else if (sel && !we) begin
      rdata <= rd_val_s;
    end else begin
      rdata <= rdata;
    end
  end

endmodule

// File: tb/tb_timer_nch.sv
// Self-checking bench for timer_nch: directed scenarios plus randomized timing checked
// against an arithmetic model of pulse times and PWM duty.
module tb_timer_nch;
  localparam int NCH = 4;
  localparam int CW  = 32;
  localparam int PSW = 8;
  localparam int AW  = 5;
  localparam int R_LOAD = 0, R_CTRL = 1, R_CMP = 2, R_STAT = 3;

  logic           clk = 1'b0;
  logic           rst, sel, we;
  logic [AW-1:0]  addr;
  logic [31:0]    wdata, rdata;
  logic [NCH-1:0] ch_out;
  logic           irq;

  int n_tests = 0;
  int n_fail  = 0;
  int hi_t[$];
  int exp_t[$];

  timer_nch #(.NCH(NCH), .CW(CW), .PSW(PSW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .sel(sel), .we(we), .addr(addr),
    .wdata(wdata), .rdata(rdata), .ch_out(ch_out), .irq(irq)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ctrl_word(input bit en, input int mode, input bit ie,
                                            input bit cas, input int psc);
    logic [7:0] p;
    logic [1:0] m;
    p = 8'(psc);
    m = 2'(mode);
    return {16'd0, p, 3'd0, cas, ie, m, en};
  endfunction

  // Expected PWM level k cycles after the enabling write: COUNT runs LOAD..0 then reloads.
  function automatic bit pwm_hi(input int k, input int l, input int c);
    int cnt;
    cnt = l - (k % (l + 1));
    return cnt < c;
  endfunction

  function automatic bit q_match();
    if (hi_t.size() != exp_t.size()) return 1'b0;
    for (int i = 0; i < hi_t.size(); i++) if (hi_t[i] != exp_t[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic string q_str(input int q[$]);
    string s;
    s = "";
    for (int i = 0; i < q.size() && i < 12; i++) s = {s, $sformatf("%0d ", q[i])};
    return s;
  endfunction

  task automatic bus_write(input int ch, input int r, input logic [31:0] d);
    sel = 1'b1; we = 1'b1; addr = AW'(ch * 4 + r); wdata = d;
    @(posedge clk); #1;
    sel = 1'b0; we = 1'b0;
  endtask

  task automatic bus_read(input int ch, input int r, output logic [31:0] d);
    sel = 1'b1; we = 1'b0; addr = AW'(ch * 4 + r);
    @(posedge clk); #1;
    d = rdata;
    sel = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic watch(input int ch, input int n);
    hi_t.delete();
    for (int k = 1; k <= n; k++) begin
      @(posedge clk); #1;
      if (ch_out[ch]) hi_t.push_back(k);
    end
  endtask

  task automatic quiesce(input int ch);
    bus_write(ch, R_CTRL, 32'd0);
    bus_write(ch, R_STAT, 32'd1);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    bus_write(0, R_LOAD, 32'd2);
    bus_write(0, R_CTRL, ctrl_word(1, 1, 1, 0, 0));
    idle(8);
    bus_read(0, R_LOAD, d);
    n_tests++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL pre_reset_irq: got %b want 1", irq); end
    rst = 1'b1; idle(2); rst = 1'b0;
    n_tests++;
    if (ch_out !== '0 || irq !== 1'b0 || rdata !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: ch_out=%h irq=%b rdata=%h want 0", ch_out, irq, rdata);
    end
    for (int ch = 0; ch < NCH; ch++) begin
      for (int r = 0; r < 4; r++) begin
        bus_read(ch, r, d);
        n_tests++;
        if (d !== 32'd0) begin n_fail++; $display("FAIL reset_reg ch%0d r%0d: got %h want 0", ch, r, d); end
      end
    end
  endtask

  task automatic test_oneshot();
    logic [31:0] d;
    bus_write(1, R_LOAD, 32'd3);
    bus_write(1, R_CTRL, ctrl_word(1, 0, 1, 0, 0));
    watch(1, 8);
    exp_t = {4};
    n_tests++;
    if (!q_match()) begin n_fail++; $display("FAIL oneshot_pulse: got [%s] want [%s]", q_str(hi_t), q_str(exp_t)); end
    n_tests++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL oneshot_irq: got %b want 1", irq); end
    bus_read(1, R_STAT, d);
    n_tests++;
    if (d !== 32'd1) begin n_fail++; $display("FAIL oneshot_status: got %h want 1", d); end
    bus_read(1, R_CTRL, d);
    n_tests++;
    if (d !== ctrl_word(0, 0, 1, 0, 0)) begin n_fail++; $display("FAIL oneshot_ctrl: got %h want %h", d, ctrl_word(0, 0, 1, 0, 0)); end
    bus_write(1, R_STAT, 32'd1);
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL oneshot_w1c_irq: got %b want 0", irq); end
  endtask

  task automatic test_periodic();
    bus_write(0, R_LOAD, 32'd4);
    bus_write(0, R_CTRL, ctrl_word(1, 1, 0, 0, 2));
    watch(0, 20);
    exp_t = {15};
    n_tests++;
    if (!q_match()) begin n_fail++; $display("FAIL periodic_first: got [%s] want [%s]", q_str(hi_t), q_str(exp_t)); end
    // Write lands 21 cycles after enable: current period ends at 30, then 6-cycle periods.
    bus_write(0, R_LOAD, 32'd1);
    watch(0, 22);
    exp_t = {9, 15, 21};
    n_tests++;
    if (!q_match()) begin n_fail++; $display("FAIL periodic_reload: got [%s] want [%s]", q_str(hi_t), q_str(exp_t)); end
    quiesce(0);
  endtask

  task automatic test_pwm();
    bus_write(2, R_CMP, 32'd3);
    bus_write(2, R_LOAD, 32'd9);
    bus_write(2, R_CTRL, ctrl_word(1, 2, 0, 0, 0));
    watch(2, 30);
    exp_t.delete();
    for (int k = 1; k <= 30; k++) if (pwm_hi(k, 9, 3)) exp_t.push_back(k);
    n_tests++;
    if (!q_match()) begin n_fail++; $display("FAIL pwm_9_3: got [%s] want [%s]", q_str(hi_t), q_str(exp_t)); end
    bus_write(2, R_CMP, 32'd0);
    watch(2, 20);
    n_tests++;
    if (hi_t.size() != 0) begin n_fail++; $display("FAIL pwm_cmp0: got %0d high cycles want 0", hi_t.size()); end
    bus_write(2, R_CMP, 32'd12);
    watch(2, 20);
    n_tests++;
    if (hi_t.size() != 20) begin n_fail++; $display("FAIL pwm_cmp12: got %0d high cycles want 20", hi_t.size()); end
    quiesce(2);
  endtask

  task automatic test_w1c_race();
    logic [31:0] d;
    bus_write(3, R_LOAD, 32'd3);
    bus_write(3, R_CTRL, ctrl_word(1, 1, 0, 0, 0));
    idle(5);
    bus_write(3, R_STAT, 32'd1);
    idle(1);
    bus_write(3, R_STAT, 32'd1);
    bus_read(3, R_STAT, d);
    n_tests++;
    if (d !== 32'd1) begin n_fail++; $display("FAIL w1c_vs_expiry: got %h want 1", d); end
    bus_write(3, R_STAT, 32'd1);
    bus_read(3, R_STAT, d);
    n_tests++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL w1c_clear: got %h want 0", d); end
    quiesce(3);
  endtask

  task automatic test_disable_restart();
    logic [31:0] d;
    bus_write(3, R_LOAD, 32'd20);
    bus_write(3, R_CTRL, ctrl_word(1, 0, 0, 0, 0));
    idle(5);
    bus_write(3, R_CTRL, ctrl_word(0, 0, 0, 0, 0));
    bus_read(3, R_CMP, d);
    n_tests++;
    if (d !== 32'd15) begin n_fail++; $display("FAIL disable_freeze: got %0d want 15", d); end
    idle(3);
    bus_read(3, R_CMP, d);
    n_tests++;
    if (d !== 32'd15) begin n_fail++; $display("FAIL disable_hold: got %0d want 15", d); end
    bus_write(3, R_CTRL, ctrl_word(1, 0, 0, 0, 0));
    bus_read(3, R_CMP, d);
    n_tests++;
    if (d !== 32'd20) begin n_fail++; $display("FAIL reenable_reload: got %0d want 20", d); end
    bus_read(3, R_CMP, d);
    n_tests++;
    if (d !== 32'd19) begin n_fail++; $display("FAIL reenable_count: got %0d want 19", d); end
    quiesce(3);
  endtask

  task automatic test_regs();
    logic [31:0] d, wd, mask, expv;
    for (int ch = 0; ch < 8; ch++) begin
      for (int r = 0; r < 2; r++) begin
        wd = $urandom();
        if (r == R_CTRL) begin
          wd[0] = 1'b0;
          mask = 32'h0000_FF0E;
`ifdef TIMER_CASCADE_EN
          mask = mask | 32'h0000_0010;
`endif
        end else begin
          mask = 32'hFFFF_FFFF;
        end
        expv = (ch < NCH) ? (wd & mask) : 32'd0;
        bus_write(ch, r, wd);
        bus_read(ch, r, d);
        n_tests++;
        if (d !== expv) begin n_fail++; $display("FAIL regs ch%0d r%0d: got %h want %h", ch, r, d, expv); end
      end
    end
    for (int ch = 0; ch < NCH; ch++) quiesce(ch);
  endtask

  task automatic test_random_timing();
    int ch, l, psc, mode, ie, p, n;
    for (int it = 0; it < 6; it++) begin
      ch = $urandom_range(NCH - 1, 0);
      l = $urandom_range(6, 0);
      psc = $urandom_range(3, 0);
      mode = $urandom_range(1, 0);
      ie = $urandom_range(1, 0);
      p = (l + 1) * (psc + 1);
      n = 3 * p + 2;
      bus_write(ch, R_LOAD, 32'(l));
      bus_write(ch, R_CTRL, ctrl_word(1, mode, ie[0], 0, psc));
      watch(ch, n);
      exp_t.delete();
      for (int k = 1; k <= n; k++) if (k % p == 0 && (mode == 1 || k == p)) exp_t.push_back(k);
      n_tests++;
      if (!q_match()) begin
        n_fail++;
        $display("FAIL rand_timing ch%0d L=%0d psc=%0d mode=%0d: got [%s] want [%s]", ch, l, psc, mode, q_str(hi_t), q_str(exp_t));
      end
      n_tests++;
      if (irq !== ie[0]) begin n_fail++; $display("FAIL rand_irq ch%0d: got %b want %0d", ch, irq, ie); end
      quiesce(ch);
      n_tests++;
      if (irq !== 1'b0) begin n_fail++; $display("FAIL rand_irq_clear ch%0d: got %b want 0", ch, irq); end
    end
  endtask

  task automatic test_random_pwm();
    int ch, l, c, n;
    for (int it = 0; it < 4; it++) begin
      ch = $urandom_range(NCH - 1, 0);
      l = $urandom_range(8, 1);
      c = $urandom_range(l + 2, 0);
      n = 2 * (l + 1) + 3;
      bus_write(ch, R_CMP, 32'(c));
      bus_write(ch, R_LOAD, 32'(l));
      bus_write(ch, R_CTRL, ctrl_word(1, 2, 0, 0, 0));
      watch(ch, n);
      exp_t.delete();
      for (int k = 1; k <= n; k++) if (pwm_hi(k, l, c)) exp_t.push_back(k);
      n_tests++;
      if (!q_match()) begin
        n_fail++;
        $display("FAIL rand_pwm ch%0d L=%0d CMP=%0d: got [%s] want [%s]", ch, l, c, q_str(hi_t), q_str(exp_t));
      end
      quiesce(ch);
    end
  endtask

  task automatic test_cascade();
    logic [31:0] d;
`ifdef TIMER_CASCADE_EN
    bus_write(1, R_LOAD, 32'd2);
    bus_write(1, R_CTRL, ctrl_word(1, 1, 0, 1, 0));
    bus_read(1, R_CTRL, d);
    n_tests++;
    if (d !== ctrl_word(1, 1, 0, 1, 0)) begin n_fail++; $display("FAIL cascade_ctrl: got %h want %h", d, ctrl_word(1, 1, 0, 1, 0)); end
    bus_write(0, R_LOAD, 32'd1);
    bus_write(0, R_CTRL, ctrl_word(1, 1, 0, 0, 0));
    watch(1, 20);
    exp_t = {6, 12, 18};
    n_tests++;
    if (!q_match()) begin n_fail++; $display("FAIL cascade_period: got [%s] want [%s]", q_str(hi_t), q_str(exp_t)); end
    quiesce(0);
    quiesce(1);
`else
    bus_write(1, R_CTRL, ctrl_word(0, 1, 0, 1, 3));
    bus_read(1, R_CTRL, d);
    n_tests++;
    if (d !== ctrl_word(0, 1, 0, 0, 3)) begin n_fail++; $display("FAIL cascade_bit_absent: got %h want %h", d, ctrl_word(0, 1, 0, 0, 3)); end
    quiesce(1);
`endif
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0; we = 1'b0; addr = '0; wdata = 32'd0;
    idle(2);
    rst = 1'b0;
    test_reset();
    test_oneshot();
    test_periodic();
    test_pwm();
    test_w1c_race();
    test_disable_restart();
    test_regs();
    test_random_timing();
    test_random_pwm();
    test_cascade();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
